// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states and bit-timing helpers.
// The TX side reuses the same timing helpers, so both ends derive identical bit periods.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Offset from the start edge to the middle of the start bit.
  function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz / baud) / 2;
  endfunction

  // Counter width able to hold cpb-1, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned cpb);
    return (cpb > 2) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with extra-MSB pointers; a pop frees the slot
// that a same-cycle push lands in, so push+pop while full is lossless.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: non-blocking assignments for every flop so all registers sample the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Forced to zero while empty so the head reads 0 out of reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, FWFT byte FIFO,
// sticky overrun and one-cycle framing-error pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned CPB  = calc_cpb(CLK_HZ, BAUD);
  localparam int unsigned HALF = calc_half(CLK_HZ, BAUD);
  localparam int unsigned CW   = calc_cnt_w(CPB);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);

  logic            rx_meta;
  logic            rx_s;
  rx_state_e       state,   state_nxt;
  logic [CW-1:0]   cnt,     cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shreg,   shreg_nxt;
  logic            push;
  logic            fe_nxt;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop_ok;

  // Both stages reset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shreg     <= shreg_nxt;
      frame_err <= fe_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    fe_nxt    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = ST_START;
      end

      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DATA;
            bit_nxt   = '0;
          end
        end
      end

      ST_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // Held-low line: wait for idle so only one framing error is reported.
        cnt_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (rd),
    .dout  (data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign valid  = ~fifo_empty;
  assign pop_ok = rd & ~fifo_empty;

  // A drop in the same cycle as a pop cannot happen (the pop frees a slot), so set wins cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !pop_ok) begin
      overrun <= 1'b1;
    end else if (pop_ok) begin
      overrun <= 1'b0;
    end
  end

endmodule
